mem_access: RTL and testbench
=============================

# mem_access

Memory-access (M) stage of the RV32 pipeline. It is the producer side of the `if_m_wb` M/WB pipeline register consumed by the writeback stage. It issues loads and stores to the data bus through a req/ack handshake and stalls the upstream EX stage while an access is outstanding. It returns aligned, sign- or zero-extended load data, or passes the ALU result through.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX presents an instruction
- `ex_ready`  out  1  M accepts it this cycle; transfer = `ex_valid & ex_ready`
- `ex_aluresult`  in  32  ALU result, or effective address for load/store
- `ex_store_data`  in  32  rs2 value for stores
- `ex_mem_load` / `ex_mem_store`  in  1 each  access type; never both set
- `ex_funct3`  in  3  access size and sign
- `ex_reg_wr`  in  1  instruction writes rd
- `ex_reg_wnum`  in  5  rd index
- `dbus_req`  out  1  access request
- `dbus_we`  out  1  1 = store
- `dbus_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`
- `dbus_be`  out  4  byte enables
- `dbus_wdata`  out  32  lane-replicated store data
- `dbus_ack`  in  1  completion; `dbus_rdata` is valid in the same cycle
- `dbus_rdata`  in  32  read word
- `if_m_wb_m`  `if_m_wb.out`  —  drives `mem_load`, `mem_dat_i_w`, `aluresult`, `reg_wr`, `reg_wnum`
- `mem_fault`  out  1  one-cycle pulse on a misaligned access or illegal funct3

## Operation
- FSM states:
  - IDLE: `ex_ready=1`, `dbus_req=0`.
  - BUSY: `ex_ready=0`, `dbus_req=1`.
- Non-memory transfer in IDLE: on the next edge, M/WB gets `aluresult=ex_aluresult`, `reg_wr=ex_reg_wr`, `reg_wnum=ex_reg_wnum`, `mem_load=0`, `mem_dat_i_w=0`.
- Legal aligned load/store transfer in IDLE:
  - Latch addr, be, wdata, we, funct3, addr[1:0], reg_wr, reg_wnum.
  - Go to BUSY; M/WB gets a bubble (all fields 0).
- BUSY, `dbus_ack=0`: hold every `dbus_*` output stable; M/WB gets a bubble.
- BUSY, `dbus_ack=1`: return to IDLE on the next edge.
  - Load: M/WB gets `mem_load=1`, `mem_dat_i_w=extended data`, `reg_wr=latched`, `reg_wnum=latched`, `aluresult=latched address`.
  - Store: M/WB gets a bubble.
- Alignment rules:
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=0`.
- Legal funct3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- Violating transfer: no bus request; stay IDLE; M/WB bubble; `mem_fault=1` for exactly the next cycle.
- Byte enables, with `o = addr[1:0]`:
  - byte: `4'b0001<<o`
  - half: `4'b0011<<o`
  - word: `4'b1111`
- Store data: byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
- Load extract: `dbus_rdata >> (8*o)`, then sign-extend for LB/LH or zero-extend for LBU/LHU; LW passes through.
- `dbus_ack` while IDLE is ignored.
- rd=x0 is forwarded unchanged; suppressing the x0 write is the register file's job.

## Timing
- Reset values: state IDLE, `dbus_req=0`, `dbus_we=0`, `dbus_addr=0`, `dbus_be=0`, `dbus_wdata=0`, `mem_fault=0`, all M/WB fields 0. `ex_ready=1` while in reset.
- `ex_ready` and `dbus_req` are decoded from registered state only; neither has a combinational path from `ex_valid` or `dbus_ack`.
- Latency:
  - non-memory op: 1 cycle to M/WB
  - memory op, ack in first BUSY cycle: 2 cycles from transfer to M/WB; each extra wait cycle adds 1
- Throughput: one non-memory op per cycle; a memory op blocks for at least 2 cycles.
- Reset mid-access: `dbus_req` drops asynchronously and the pending access is abandoned. A late ack is ignored.
- The bus slave must not ack in a cycle where `dbus_req=0`.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
  - state enum `mstate_t {M_IDLE, M_BUSY}`
  - struct `mem_req_t` {addr, be, wdata, we, funct3, off, reg_wr, reg_wnum}
- Sub-module `mem_align`: purely combinational. Produces be, wdata, the misalign/illegal flag, and load extract/extend.
- `mem_access` holds the FSM, the request latch and the M/WB register.

## Test plan
- ADD result 0x0000_1234, rd=5 -> next cycle M/WB `aluresult=0x1234`, `reg_wr=1`, `reg_wnum=5`, `mem_load=0`.
- LB at 0x103, ack after 2 wait cycles with rdata 0x80FF_0000 -> be=4'b1000, addr 0x100, `mem_dat_i_w=0xFFFF_FF80`. Output appears 4 cycles after transfer; `ex_ready=0` for 3 cycles.
- LHU at 0x102, rdata 0xBEEF_0000, immediate ack -> be=4'b1100, `mem_dat_i_w=0x0000_BEEF`, `mem_load=1`.
- SB 0xAB at 0x201 -> be=4'b0010, wdata 0xABAB_ABAB, `dbus_we=1`; M/WB `reg_wr=0`.
- LW at 0x302 -> no `dbus_req`; `mem_fault` pulses once; M/WB bubble; the next instruction is accepted the following cycle.
- Assert `rst_n` low in BUSY, then ack on release -> `dbus_req=0` immediately; the ack is ignored; M/WB stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the M stage: funct3 codes, FSM states, latched request.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        M_IDLE,
        M_BUSY
    } mstate_t;

    // Request captured on a legal load/store transfer and held while BUSY.
    // addr keeps the full effective address; off duplicates addr[1:0] for
    // the load extractor.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic        reg_wr;
        logic [4:0]  reg_wnum;
    } mem_req_t;

endpackage

// File: rtl/if_m_wb.sv
// M/WB pipeline register bundle between the M stage and writeback.
interface if_m_wb #(
    parameter int XLEN = 32
);
    logic            mem_load;
    logic [XLEN-1:0] mem_dat_i_w;
    logic [XLEN-1:0] aluresult;
    logic            reg_wr;
    logic [4:0]      reg_wnum;

    modport out (
        output mem_load,
        output mem_dat_i_w,
        output aluresult,
        output reg_wr,
        output reg_wnum
    );

    modport in (
        input mem_load,
        input mem_dat_i_w,
        input aluresult,
        input reg_wr,
        input reg_wnum
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store replication, legality check,
// and load extraction with sign/zero extension.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  enc_funct3,
    input  logic [1:0]  enc_off,
    input  logic        enc_load,
    input  logic        enc_store,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        fault,
    input  logic [2:0]  ext_funct3,
    input  logic [1:0]  ext_off,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic        legal;
    logic        misaligned;
    logic [31:0] shifted;

    // Encode side: enables, replicated store data and fault flag.
    always_comb begin
        be         = 4'b1111;
        wdata      = st_data;
        legal      = 1'b0;
        misaligned = 1'b0;
        case (enc_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << enc_off;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << enc_off;
                wdata      = {2{st_data[15:0]}};
                misaligned = enc_off[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = st_data;
                misaligned = (enc_off != 2'b00);
            end
        endcase
        if (enc_load) begin
            legal = (enc_funct3 == F3_B)  || (enc_funct3 == F3_H) ||
                    (enc_funct3 == F3_W)  || (enc_funct3 == F3_BU) ||
                    (enc_funct3 == F3_HU);
        end else if (enc_store) begin
            legal = (enc_funct3 == F3_B) || (enc_funct3 == F3_H) ||
                    (enc_funct3 == F3_W);
        end
        fault = (enc_load | enc_store) & (~legal | misaligned);
    end

    // Extract side: shift the addressed lane down, then extend.
    always_comb begin
        shifted = rdata >> {ext_off, 3'b000};
        case (ext_funct3)
            F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ldata = {24'd0, shifted[7:0]};
            F3_HU:   ldata = {16'd0, shifted[15:0]};
            default: ldata = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32 memory-access stage: request FSM, request latch and M/WB register.
module mem_access
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_aluresult,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_mem_load,
    input  logic            ex_mem_store,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_reg_wr,
    input  logic [4:0]      ex_reg_wnum,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [3:0]      dbus_be,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata,
    if_m_wb.out             if_m_wb_m,
    output logic            mem_fault
);

    mstate_t         state_q, state_d;
    mem_req_t        req_q, req_d;
    logic            fault_q, fault_d;
    logic            wb_load_q, wb_load_d;
    logic [XLEN-1:0] wb_dat_q, wb_dat_d;
    logic [XLEN-1:0] wb_alu_q, wb_alu_d;
    logic            wb_rw_q, wb_rw_d;
    logic [4:0]      wb_wnum_q, wb_wnum_d;

    logic [3:0]      enc_be;
    logic [31:0]     enc_wdata;
    logic            enc_fault;
    logic [31:0]     ldata;

    mem_align u_align (
        .enc_funct3 (ex_funct3),
        .enc_off    (ex_aluresult[1:0]),
        .enc_load   (ex_mem_load),
        .enc_store  (ex_mem_store),
        .st_data    (ex_store_data),
        .be         (enc_be),
        .wdata      (enc_wdata),
        .fault      (enc_fault),
        .ext_funct3 (req_q.funct3),
        .ext_off    (req_q.off),
        .rdata      (dbus_rdata),
        .ldata      (ldata)
    );

    // State, request latch, fault pulse and M/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= M_IDLE;
            req_q     <= '0;
            fault_q   <= 1'b0;
            wb_load_q <= 1'b0;
            wb_dat_q  <= '0;
            wb_alu_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_wnum_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            fault_q   <= fault_d;
            wb_load_q <= wb_load_d;
            wb_dat_q  <= wb_dat_d;
            wb_alu_q  <= wb_alu_d;
            wb_rw_q   <= wb_rw_d;
            wb_wnum_q <= wb_wnum_d;
        end
    end

    // Next state; M/WB defaults to a bubble unless something completes.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        fault_d   = 1'b0;
        wb_load_d = 1'b0;
        wb_dat_d  = '0;
        wb_alu_d  = '0;
        wb_rw_d   = 1'b0;
        wb_wnum_d = '0;
        case (state_q)
            M_IDLE: begin
                if (ex_valid) begin
                    if (!(ex_mem_load || ex_mem_store)) begin
                        wb_alu_d  = ex_aluresult;
                        wb_rw_d   = ex_reg_wr;
                        wb_wnum_d = ex_reg_wnum;
                    end else if (enc_fault) begin
                        fault_d = 1'b1;
                    end else begin
                        req_d = '{addr:     ex_aluresult,
                                  be:       enc_be,
                                  wdata:    enc_wdata,
                                  we:       ex_mem_store,
                                  funct3:   ex_funct3,
                                  off:      ex_aluresult[1:0],
                                  reg_wr:   ex_reg_wr,
                                  reg_wnum: ex_reg_wnum};
                        state_d = M_BUSY;
                    end
                end
            end
            M_BUSY: begin
                if (dbus_ack) begin
                    state_d = M_IDLE;
                    if (!req_q.we) begin
                        wb_load_d = 1'b1;
                        wb_dat_d  = ldata;
                        wb_alu_d  = req_q.addr;
                        wb_rw_d   = req_q.reg_wr;
                        wb_wnum_d = req_q.reg_wnum;
                    end
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    assign ex_ready   = (state_q == M_IDLE);
    assign dbus_req   = (state_q == M_BUSY);
    assign dbus_we    = req_q.we;
    assign dbus_addr  = {req_q.addr[31:2], 2'b00};
    assign dbus_be    = req_q.be;
    assign dbus_wdata = req_q.wdata;
    assign mem_fault  = fault_q;

    assign if_m_wb_m.mem_load    = wb_load_q;
    assign if_m_wb_m.mem_dat_i_w = wb_dat_q;
    assign if_m_wb_m.aluresult   = wb_alu_q;
    assign if_m_wb_m.reg_wr      = wb_rw_q;
    assign if_m_wb_m.reg_wnum    = wb_wnum_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of expected M/WB records.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_aluresult = '0;
    logic [31:0] ex_store_data = '0;
    logic        ex_mem_load = 1'b0;
    logic        ex_mem_store = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_reg_wr = 1'b0;
    logic [4:0]  ex_reg_wnum = '0;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        mem_fault;

    if_m_wb #(.XLEN(32)) m_wb ();

    mem_access #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_aluresult  (ex_aluresult),
        .ex_store_data (ex_store_data),
        .ex_mem_load   (ex_mem_load),
        .ex_mem_store  (ex_mem_store),
        .ex_funct3     (ex_funct3),
        .ex_reg_wr     (ex_reg_wr),
        .ex_reg_wnum   (ex_reg_wnum),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_be       (dbus_be),
        .dbus_wdata    (dbus_wdata),
        .dbus_ack      (dbus_ack),
        .dbus_rdata    (dbus_rdata),
        .if_m_wb_m     (m_wb),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    // {mem_load, mem_dat_i_w, aluresult, reg_wr, reg_wnum}
    typedef logic [70:0] wb_t;
    wb_t sb[$];
    int  errors = 0;
    int  checks = 0;

    wire [70:0] wb_obs = {m_wb.mem_load, m_wb.mem_dat_i_w, m_wb.aluresult,
                          m_wb.reg_wr, m_wb.reg_wnum};

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, wb_obs);
        end else begin
            e = sb.pop_front();
            chk(tag, {9'd0, wb_obs}, {9'd0, e});
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic ld, input logic st, input logic [2:0] f3,
                         input logic rw, input logic [4:0] wn);
        ex_valid      = v;
        ex_aluresult  = alu;
        ex_store_data = sd;
        ex_mem_load   = ld;
        ex_mem_store  = st;
        ex_funct3     = f3;
        ex_reg_wr     = rw;
        ex_reg_wnum   = wn;
    endtask

    task automatic idle_in();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0);
    endtask

    // Issue one legal load/store at a negedge and serve it after 'waits' wait cycles.
    task automatic mem_op(input string tag, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                          input logic rw, input logic [4:0] wn, input int unsigned waits,
                          input logic [31:0] rdata, input logic [3:0] be_e,
                          input logic [31:0] wd_e, input logic [31:0] ld_e);
        drive(1'b1, addr, sd, ld, st, f3, rw, wn);
        @(negedge clk);
        idle_in();
        for (int unsigned i = 0; i <= waits; i++) begin
            chk({tag, "_ready_busy"}, 80'(ex_ready), 80'(1'b0));
            chk({tag, "_req"}, 80'(dbus_req), 80'(1'b1));
            chk({tag, "_addr"}, 80'(dbus_addr), 80'({addr[31:2], 2'b00}));
            chk({tag, "_be"}, 80'(dbus_be), 80'(be_e));
            chk({tag, "_we"}, 80'(dbus_we), 80'(st));
            if (st) chk({tag, "_wdata"}, 80'(dbus_wdata), 80'(wd_e));
            chk({tag, "_wb_bubble"}, 80'(wb_obs), 80'(0));
            if (i == waits) begin
                dbus_ack   = 1'b1;
                dbus_rdata = rdata;
                if (ld) sb.push_back({1'b1, ld_e, addr, rw, wn});
                else    sb.push_back('0);
            end
            @(negedge clk);
        end
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        chk_wb({tag, "_wb"});
        chk({tag, "_ready_done"}, 80'(ex_ready), 80'(1'b1));
        chk({tag, "_req_done"}, 80'(dbus_req), 80'(1'b0));
    endtask

    // Issue an illegal access; the following ALU op must be accepted next cycle.
    task automatic fault_op(input string tag, input logic ld, input logic st,
                            input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] nxt);
        drive(1'b1, addr, 32'h5555_5555, ld, st, f3, 1'b1, 5'd9);
        @(negedge clk);
        drive(1'b1, nxt, '0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd3);
        sb.push_back({1'b0, 32'd0, nxt, 1'b1, 5'd3});
        chk({tag, "_fault"}, 80'(mem_fault), 80'(1'b1));
        chk({tag, "_noreq"}, 80'(dbus_req), 80'(1'b0));
        chk({tag, "_ready"}, 80'(ex_ready), 80'(1'b1));
        chk({tag, "_wb_bubble"}, 80'(wb_obs), 80'(0));
        @(negedge clk);
        idle_in();
        chk({tag, "_fault_clear"}, 80'(mem_fault), 80'(1'b0));
        chk_wb({tag, "_next_op"});
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", 80'(ex_ready), 80'(1'b1));
        chk("rst_req", 80'(dbus_req), 80'(1'b0));
        chk("rst_bus", 80'({dbus_we, dbus_addr, dbus_be, dbus_wdata}), 80'(0));
        chk("rst_fault", 80'(mem_fault), 80'(1'b0));
        chk("rst_wb", 80'(wb_obs), 80'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back non-memory ops, the second to x0
        drive(1'b1, 32'h0000_1234, '0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd5);
        sb.push_back({1'b0, 32'd0, 32'h0000_1234, 1'b1, 5'd5});
        @(negedge clk);
        drive(1'b1, 32'hDEAD_BEEF, '0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd0);
        sb.push_back({1'b0, 32'd0, 32'hDEAD_BEEF, 1'b1, 5'd0});
        chk_wb("add_wb");
        chk("add_ready", 80'(ex_ready), 80'(1'b1));
        @(negedge clk);
        idle_in();
        chk_wb("x0_wb");
        @(negedge clk);
        chk("idle_bubble", 80'(wb_obs), 80'(0));

        // Loads and stores
        mem_op("lb", 1'b1, 1'b0, 32'h0000_0103, '0, 3'd0, 1'b1, 5'd7, 2,
               32'h80FF_0000, 4'b1000, '0, 32'hFFFF_FF80);
        mem_op("lhu", 1'b1, 1'b0, 32'h0000_0102, '0, 3'd5, 1'b1, 5'd8, 0,
               32'hBEEF_0000, 4'b1100, '0, 32'h0000_BEEF);
        mem_op("sb", 1'b0, 1'b1, 32'h0000_0201, 32'h1234_56AB, 3'd0, 1'b0, 5'd0, 1,
               '0, 4'b0010, 32'hABAB_ABAB, '0);
        mem_op("sh", 1'b0, 1'b1, 32'h0000_0202, 32'h7777_CAFE, 3'd1, 1'b1, 5'd4, 0,
               '0, 4'b1100, 32'hCAFE_CAFE, '0);
        mem_op("sw", 1'b0, 1'b1, 32'h0000_0300, 32'h0102_0304, 3'd2, 1'b0, 5'd0, 0,
               '0, 4'b1111, 32'h0102_0304, '0);
        mem_op("lh", 1'b1, 1'b0, 32'h0000_0100, '0, 3'd1, 1'b1, 5'd10, 1,
               32'h1111_8001, 4'b0011, '0, 32'hFFFF_8001);
        mem_op("lw", 1'b1, 1'b0, 32'h0000_0400, '0, 3'd2, 1'b1, 5'd11, 0,
               32'h1234_5678, 4'b1111, '0, 32'h1234_5678);
        mem_op("lbu", 1'b1, 1'b0, 32'h0000_0101, '0, 3'd4, 1'b1, 5'd12, 0,
               32'h0000_A500, 4'b0010, '0, 32'h0000_00A5);

        // Faults: misaligned word/half, illegal load and store funct3
        fault_op("lw_mis", 1'b1, 1'b0, 32'h0000_0302, 3'd2, 32'h0000_A001);
        fault_op("lh_mis", 1'b1, 1'b0, 32'h0000_0101, 3'd1, 32'h0000_A002);
        fault_op("ld_f3", 1'b1, 1'b0, 32'h0000_0000, 3'd3, 32'h0000_A003);
        fault_op("st_f3", 1'b0, 1'b1, 32'h0000_0000, 3'd4, 32'h0000_A004);

        // Ack in IDLE is ignored
        dbus_ack = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dbus_ack = 1'b0;
        chk("idle_ack_ready", 80'(ex_ready), 80'(1'b1));
        chk("idle_ack_req", 80'(dbus_req), 80'(1'b0));
        chk("idle_ack_wb", 80'(wb_obs), 80'(0));

        // Reset during BUSY, then a late ack after release
        drive(1'b1, 32'h0000_0500, '0, 1'b1, 1'b0, 3'd2, 1'b1, 5'd13);
        @(negedge clk);
        idle_in();
        chk("mid_busy_req", 80'(dbus_req), 80'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 80'(dbus_req), 80'(1'b0));
        chk("mid_rst_ready", 80'(ex_ready), 80'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        dbus_ack = 1'b1;
        dbus_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        dbus_ack = 1'b0;
        chk("late_ack_req", 80'(dbus_req), 80'(1'b0));
        chk("late_ack_wb", 80'(wb_obs), 80'(0));
        chk("late_ack_ready", 80'(ex_ready), 80'(1'b1));
        chk("late_ack_addr", 80'(dbus_addr), 80'(0));
        chk("sb_drained", 80'(sb.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
